// File: rtl/dual_cmos_pkg.sv
// Shared definitions for the dual-camera line scheduler: mode codes, FSM states,
// RGB565 field positions and the per-channel averaging helper.
package dual_cmos_pkg;

  localparam logic [1:0] MODE_SBS   = 2'd0;
  localparam logic [1:0] MODE_CAM0  = 2'd1;
  localparam logic [1:0] MODE_CAM1  = 2'd2;
  localparam logic [1:0] MODE_BLEND = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StWait,
    StOutA,
    StOutB,
    StHblank
  } state_e;

  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  // One extra bit per channel so the sum never wraps before the halving shift.
  function automatic logic [15:0] blend565(input logic [15:0] a, input logic [15:0] b);
    logic [5:0] r_sum;
    logic [6:0] g_sum;
    logic [5:0] b_sum;
    r_sum = {1'b0, a[R_MSB:R_LSB]} + {1'b0, b[R_MSB:R_LSB]};
    g_sum = {1'b0, a[G_MSB:G_LSB]} + {1'b0, b[G_MSB:G_LSB]};
    b_sum = {1'b0, a[B_MSB:B_LSB]} + {1'b0, b[B_MSB:B_LSB]};
    return {r_sum[5:1], g_sum[6:1], b_sum[5:1]};
  endfunction

endpackage

// File: rtl/dual_line_sched_if.sv
// Control, FIFO and pixel-output bundle of the dual-camera line scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface dual_line_sched_if;
  logic        frame_start;
  logic [1:0]  mode;
  logic        line_done0;
  logic        line_done1;
  logic        fifo0_rd_en;
  logic [15:0] fifo0_q;
  logic        fifo0_empty;
  logic        fifo1_rd_en;
  logic [15:0] fifo1_q;
  logic        fifo1_empty;
  logic        pixel_vsync;
  logic        pixel_href;
  logic [15:0] pixel_data;
  logic [10:0] line_cnt;
  logic        err_clr;
  logic        ovf_err;
  logic        miss_err;
  logic        urun_err;

  modport master (
    output frame_start, mode, line_done0, line_done1, fifo0_q, fifo0_empty,
           fifo1_q, fifo1_empty, err_clr,
    input  fifo0_rd_en, fifo1_rd_en, pixel_vsync, pixel_href, pixel_data, line_cnt,
           ovf_err, miss_err, urun_err
  );

  modport slave (
    input  frame_start, mode, line_done0, line_done1, fifo0_q, fifo0_empty,
           fifo1_q, fifo1_empty, err_clr,
    output fifo0_rd_en, fifo1_rd_en, pixel_vsync, pixel_href, pixel_data, line_cnt,
           ovf_err, miss_err, urun_err
  );
endinterface

// File: rtl/line_credit_cnt.sv
// Saturating up/down count of completed lines waiting in one camera FIFO.
// ovf_o pulses when an increment is dropped at the maximum count.
module line_credit_cnt #(
  parameter int unsigned CW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);

  localparam logic [CW-1:0] CntMax = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CntMax) ovf_o = 1'b1;
      else                 cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dual_line_sched.sv
// Credit-based line sequencer merging two camera line FIFOs into one RGB565
// stream (side-by-side, single camera or 50/50 blend) with regenerated vsync/href.
module dual_line_sched
  import dual_cmos_pkg::*;
#(
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_ACT   = 720,
  parameter int unsigned HBLANK  = 16,
  parameter int unsigned VS_LEN  = 4,
  parameter int unsigned TIMEOUT = 2048,
  parameter int unsigned CW      = 2
) (
  input logic              cmos_pclk,
  input logic              sys_rst_n,
  dual_line_sched_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + H_ACT + HBLANK + VS_LEN);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic            pend_q, pend_d, zf0_q, zf0_d, zf1_q, zf1_d;
  logic [10:0]     line_cnt_q, line_cnt_d;
  logic            href_q, href_d, use0_q, use0_d, use1_q, use1_d;
  logic            blend_q, blend_d, urun_px_q, urun_px_d;
  logic            ovf_err_q, ovf_err_d, miss_err_q, miss_err_d, urun_err_q, urun_err_d;
  logic [CW-1:0]   cred0, cred1;
  logic            ovf0, ovf1, dec0, dec1, miss_set, line_end, rd0, rd1;
  logic            req0, req1, have0, have1;
  logic [15:0]     pix_a, pix_b, pixel_data;

  line_credit_cnt #(.CW(CW)) u_cred0 (
    .clk_i (cmos_pclk),
    .rst_ni(sys_rst_n),
    .inc_i (bus.line_done0),
    .dec_i (dec0),
    .cnt_o (cred0),
    .ovf_o (ovf0)
  );

  line_credit_cnt #(.CW(CW)) u_cred1 (
    .clk_i (cmos_pclk),
    .rst_ni(sys_rst_n),
    .inc_i (bus.line_done1),
    .dec_i (dec1),
    .cnt_o (cred1),
    .ovf_o (ovf1)
  );

  always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    mode_d      = mode_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    zf0_d       = zf0_q;
    zf1_d       = zf1_q;
    line_cnt_d  = line_cnt_q;
    dec0        = 1'b0;
    dec1        = 1'b0;
    miss_set    = 1'b0;
    line_end    = 1'b0;
    req0        = (mode_q != MODE_CAM1);
    req1        = (mode_q != MODE_CAM0);
    have0       = (cred0 != '0);
    have1       = (cred1 != '0);
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus.frame_start) begin
          state_d = StVsync;
          mode_d  = bus.mode;
        end
      end
      StVsync: begin
        line_cnt_d = '0;
        if (cnt_q == CntW'(VS_LEN - 1)) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // Side-by-side takes its cam0 credit when the right half starts, not here.
        if ((!req0 || have0) && (!req1 || have1)) begin
          state_d = StOutA;
          cnt_d   = '0;
          zf0_d   = 1'b0;
          zf1_d   = 1'b0;
          dec0    = req0 && (mode_q != MODE_SBS);
          dec1    = req1;
        end else if (req0 && req1 && (have0 != have1)) begin
          if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_d  = StOutA;
            cnt_d    = '0;
            zf0_d    = !have0;
            zf1_d    = !have1;
            dec0     = have0 && (mode_q != MODE_SBS);
            dec1     = have1;
            miss_set = 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      StOutA: begin
        if (cnt_q == CntW'(H_ACT - 1)) begin
          cnt_d = '0;
          if (mode_q == MODE_SBS) begin
            state_d = StOutB;
            dec0    = !zf0_q;
          end else begin
            line_end = 1'b1;
          end
        end
      end
      StOutB: begin
        if (cnt_q == CntW'(H_ACT - 1)) begin
          cnt_d    = '0;
          line_end = 1'b1;
        end
      end
      StHblank: begin
        if (cnt_q == CntW'(HBLANK - 1)) begin
          cnt_d = '0;
          if (line_cnt_q == 11'(V_ACT)) begin
            state_d    = StIdle;
            line_cnt_d = '0;
          end else begin
            state_d = StWait;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A frame start seen during a line is deferred until that line has been emitted.
    if (line_end) begin
      if (pend_q || bus.frame_start) begin
        state_d = StVsync;
        mode_d  = bus.frame_start ? bus.mode : pend_mode_q;
        pend_d  = 1'b0;
      end else begin
        state_d    = StHblank;
        line_cnt_d = line_cnt_q + 11'd1;
      end
    end else if (bus.frame_start) begin
      if (state_q inside {StOutA, StOutB}) begin
        pend_d      = 1'b1;
        pend_mode_d = bus.mode;
      end else if (state_q inside {StVsync, StWait, StHblank}) begin
        state_d  = StVsync;
        mode_d   = bus.mode;
        cnt_d    = '0;
        dec0     = 1'b0;
        dec1     = 1'b0;
        miss_set = 1'b0;
        zf0_d    = zf0_q;
        zf1_d    = zf1_q;
      end
    end
  end

  always_comb begin
    rd0 = 1'b0;
    rd1 = 1'b0;
    unique case (state_q)
      StOutA: begin
        rd0 = (mode_q == MODE_CAM0 || mode_q == MODE_BLEND) && !zf0_q;
        rd1 = (mode_q != MODE_CAM0) && !zf1_q;
      end
      StOutB:  rd0 = !zf0_q;
      default: ;
    endcase
  end

  always_comb begin
    href_d     = state_q inside {StOutA, StOutB};
    use0_d     = rd0;
    use1_d     = rd1;
    blend_d    = (state_q == StOutA) && (mode_q == MODE_BLEND);
    urun_px_d  = (rd0 && bus.fifo0_empty) || (rd1 && bus.fifo1_empty);
    ovf_err_d  = ovf0 || ovf1 || (ovf_err_q && !bus.err_clr);
    miss_err_d = miss_set || (miss_err_q && !bus.err_clr);
    urun_err_d = urun_px_d || (urun_err_q && !bus.err_clr);
  end

  always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q       <= '0;
      mode_q      <= MODE_SBS;
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_SBS;
      zf0_q       <= 1'b0;
      zf1_q       <= 1'b0;
      line_cnt_q  <= '0;
      href_q      <= 1'b0;
      use0_q      <= 1'b0;
      use1_q      <= 1'b0;
      blend_q     <= 1'b0;
      urun_px_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      miss_err_q  <= 1'b0;
      urun_err_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      zf0_q       <= zf0_d;
      zf1_q       <= zf1_d;
      line_cnt_q  <= line_cnt_d;
      href_q      <= href_d;
      use0_q      <= use0_d;
      use1_q      <= use1_d;
      blend_q     <= blend_d;
      urun_px_q   <= urun_px_d;
      ovf_err_q   <= ovf_err_d;
      miss_err_q  <= miss_err_d;
      urun_err_q  <= urun_err_d;
    end
  end

  // FIFO data arrives the cycle after the read, aligned with href_q.
  always_comb begin
    pix_a = use0_q ? bus.fifo0_q : 16'h0000;
    pix_b = use1_q ? bus.fifo1_q : 16'h0000;
    if (!href_q || urun_px_q) pixel_data = 16'h0000;
    else if (blend_q)         pixel_data = blend565(pix_a, pix_b);
    else                      pixel_data = pix_a | pix_b;
  end

  assign bus.fifo0_rd_en = rd0;
  assign bus.fifo1_rd_en = rd1;
  assign bus.pixel_vsync = (state_q == StVsync);
  assign bus.pixel_href  = href_q;
  assign bus.pixel_data  = pixel_data;
  assign bus.line_cnt    = line_cnt_q;
  assign bus.ovf_err     = ovf_err_q;
  assign bus.miss_err    = miss_err_q;
  assign bus.urun_err    = urun_err_q;

endmodule

// File: tb/tb_dual_line_sched.sv
// Directed bench for dual_line_sched: FIFO models return indexed patterns and
// each scenario task compares captured lines against hand-derived expectations.
module tb_dual_line_sched;
  import dual_cmos_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_line_sched_if bus ();

  dual_line_sched #(.V_ACT(4)) u_dut (
    .cmos_pclk(clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [11:0] idx0, idx1;
  logic        blend_pat = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx0 <= '0;
      bus.fifo0_q <= '0;
    end else if (bus.fifo0_rd_en) begin
      bus.fifo0_q <= blend_pat ? 16'hF81F : {4'hA, idx0};
      idx0 <= idx0 + 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx1 <= '0;
      bus.fifo1_q <= '0;
    end else if (bus.fifo1_rd_en) begin
      bus.fifo1_q <= blend_pat ? 16'h07E0 : {4'h5, idx1};
      idx1 <= idx1 + 1'b1;
    end
  end

  logic [15:0] pix [0:1499];
  int rd0_cnt, rd1_cnt, vs_during;

  task automatic pulse_fs(input logic [1:0] m);
    bus.mode = m;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_ld(input logic [1:0] m);
    bus.line_done0 = m[0];
    bus.line_done1 = m[1];
    @(negedge clk);
    bus.line_done0 = 1'b0;
    bus.line_done1 = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  task automatic wait_vsync(output int vl);
    int w = 0;
    vl = 0;
    while (bus.pixel_vsync !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    while (bus.pixel_vsync === 1'b1 && vl < 50) begin @(negedge clk); vl++; end
  endtask

  // Waits (bounded) for href, then records the contiguous active run.
  task automatic capture_line(input int bound, input int fs_at, input logic [1:0] fs_mode,
                              output int waited, output int len);
    waited = 0;
    len = 0;
    rd0_cnt = 0;
    rd1_cnt = 0;
    vs_during = 0;
    while (bus.pixel_href !== 1'b1 && waited < bound) begin
      rd0_cnt += int'(bus.fifo0_rd_en);
      rd1_cnt += int'(bus.fifo1_rd_en);
      @(negedge clk);
      waited++;
    end
    while (bus.pixel_href === 1'b1 && len < 1500) begin
      pix[len] = bus.pixel_data;
      rd0_cnt += int'(bus.fifo0_rd_en);
      rd1_cnt += int'(bus.fifo1_rd_en);
      vs_during += int'(bus.pixel_vsync);
      if (len == fs_at) bus.mode = fs_mode;
      bus.frame_start = (len == fs_at);
      len++;
      @(negedge clk);
    end
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pixel_vsync, bus.pixel_href, bus.fifo0_rd_en, bus.fifo1_rd_en} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000", {bus.pixel_vsync, bus.pixel_href,
               bus.fifo0_rd_en, bus.fifo1_rd_en});
    end
    checks++;
    if ({bus.ovf_err, bus.miss_err, bus.urun_err} !== 3'b0) begin
      failures++;
      $display("FAIL reset_err: got %b want 000", {bus.ovf_err, bus.miss_err, bus.urun_err});
    end
    checks++;
    if (bus.pixel_data !== 16'h0 || bus.line_cnt !== 11'd0) begin
      failures++;
      $display("FAIL reset_data: data %h line_cnt %0d want 0/0", bus.pixel_data, bus.line_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sbs();
    int vl, waited, len, bad_l, bad_r, bl;
    logic [11:0] b0, b1;
    pulse_fs(MODE_SBS);
    wait_vsync(vl);
    checks++;
    if (vl != 4) begin failures++; $display("FAIL sbs_vsync_len: got %0d want 4", vl); end
    b0 = idx0;
    b1 = idx1;
    pulse_ld(2'b11);
    capture_line(100, -1, 2'd0, waited, len);
    checks++;
    if (len != 1280) begin failures++; $display("FAIL sbs_href_len: got %0d want 1280", len); end
    bad_l = 0;
    bad_r = 0;
    for (int i = 0; i < 640; i++) begin
      if (pix[i] !== {4'h5, 12'(b1 + i)}) bad_l++;
      if (pix[640+i] !== {4'hA, 12'(b0 + i)}) bad_r++;
    end
    checks++;
    if (bad_l != 0) begin failures++; $display("FAIL sbs_left_cam1: bad %0d want 0", bad_l); end
    checks++;
    if (bad_r != 0) begin failures++; $display("FAIL sbs_right_cam0: bad %0d want 0", bad_r); end
    bl = 0;
    repeat (16) begin
      if (bus.pixel_href !== 1'b0 || bus.pixel_data !== 16'h0) bl++;
      @(negedge clk);
    end
    checks++;
    if (bl != 0) begin failures++; $display("FAIL sbs_hblank: active %0d want 0", bl); end
    checks++;
    if (bus.line_cnt !== 11'd1) begin
      failures++;
      $display("FAIL sbs_line_cnt: got %0d want 1", bus.line_cnt);
    end
  endtask

  task automatic test_blend();
    int vl, waited, len, bad;
    blend_pat = 1'b1;
    pulse_fs(MODE_BLEND);
    wait_vsync(vl);
    pulse_ld(2'b11);
    capture_line(100, -1, 2'd0, waited, len);
    blend_pat = 1'b0;
    checks++;
    if (len != 640) begin failures++; $display("FAIL blend_href_len: got %0d want 640", len); end
    bad = 0;
    for (int i = 0; i < 640; i++) if (pix[i] !== 16'h7BEF) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL blend_data: bad %0d first %h want 7bef", bad, pix[0]);
    end
    checks++;
    if (bus.line_cnt !== 11'd1) begin
      failures++;
      $display("FAIL blend_line_cnt: got %0d want 1", bus.line_cnt);
    end
  endtask

  task automatic test_timeout();
    int vl, waited, len, bad_l, bad_r;
    logic [11:0] b1;
    pulse_fs(MODE_SBS);
    wait_vsync(vl);
    b1 = idx1;
    pulse_ld(2'b10);
    capture_line(2300, -1, 2'd0, waited, len);
    checks++;
    if (waited < 2048 || waited > 2060) begin
      failures++;
      $display("FAIL tmo_wait: got %0d want 2048..2060", waited);
    end
    checks++;
    if (len != 1280) begin failures++; $display("FAIL tmo_href_len: got %0d want 1280", len); end
    bad_l = 0;
    bad_r = 0;
    for (int i = 0; i < 640; i++) begin
      if (pix[i] !== {4'h5, 12'(b1 + i)}) bad_l++;
      if (pix[640+i] !== 16'h0) bad_r++;
    end
    checks++;
    if (bad_l != 0 || bad_r != 0) begin
      failures++;
      $display("FAIL tmo_data: bad left %0d right %0d want 0/0", bad_l, bad_r);
    end
    checks++;
    if (rd0_cnt != 0) begin failures++; $display("FAIL tmo_rd0: got %0d want 0", rd0_cnt); end
    checks++;
    if (bus.miss_err !== 1'b1 || bus.urun_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_flags: miss %b urun %b want 1/0", bus.miss_err, bus.urun_err);
    end
    checks++;
    if (u_dut.cred0 !== 2'd0) begin
      failures++;
      $display("FAIL tmo_cred0: got %0d want 0", u_dut.cred0);
    end
  endtask

  task automatic test_fs_mid_line();
    int vl, waited, len, bad;
    logic [11:0] b0, b1;
    pulse_fs(MODE_CAM0);
    wait_vsync(vl);
    b0 = idx0;
    pulse_ld(2'b01);
    capture_line(100, 100, MODE_CAM1, waited, len);
    checks++;
    if (len != 640) begin failures++; $display("FAIL fsmid_len: got %0d want 640", len); end
    bad = 0;
    for (int i = 0; i < 640; i++) if (pix[i] !== {4'hA, 12'(b0 + i)}) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL fsmid_data: bad %0d want 0", bad); end
    wait_vsync(vl);
    checks++;
    if (vs_during + vl != 4) begin
      failures++;
      $display("FAIL fsmid_vsync: got %0d+%0d want 4 total", vs_during, vl);
    end
    checks++;
    if (bus.line_cnt !== 11'd0) begin
      failures++;
      $display("FAIL fsmid_line_cnt: got %0d want 0", bus.line_cnt);
    end
    b1 = idx1;
    pulse_ld(2'b10);
    capture_line(100, -1, 2'd0, waited, len);
    bad = 0;
    for (int i = 0; i < 640; i++) if (pix[i] !== {4'h5, 12'(b1 + i)}) bad++;
    checks++;
    if (len != 640 || bad != 0 || rd0_cnt != 0) begin
      failures++;
      $display("FAIL fsmid_new_mode: len %0d bad %0d rd0 %0d want 640/0/0", len, bad, rd0_cnt);
    end
  endtask

  task automatic test_vact();
    int rises, act;
    logic prev;
    repeat (3) pulse_ld(2'b10);
    rises = 0;
    prev = 1'b0;
    repeat (2400) begin
      if (bus.pixel_href === 1'b1 && !prev) rises++;
      prev = bus.pixel_href;
      @(negedge clk);
    end
    checks++;
    if (rises != 3) begin failures++; $display("FAIL vact_lines: got %0d want 3", rises); end
    checks++;
    if (u_dut.state_q !== StIdle) begin
      failures++;
      $display("FAIL vact_idle: got %0d want %0d", u_dut.state_q, StIdle);
    end
    repeat (2) pulse_ld(2'b10);
    act = 0;
    repeat (200) begin
      if (bus.pixel_href !== 1'b0 || bus.fifo1_rd_en !== 1'b0) act++;
      @(negedge clk);
    end
    checks++;
    if (act != 0) begin failures++; $display("FAIL vact_no_href: got %0d want 0", act); end
    checks++;
    if (u_dut.cred1 !== 2'd2) begin
      failures++;
      $display("FAIL vact_cred1: got %0d want 2", u_dut.cred1);
    end
  endtask

  task automatic test_ovf();
    repeat (5) pulse_ld(2'b01);
    checks++;
    if (u_dut.cred0 !== 2'd3 || bus.ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: cred0 %0d ovf %b want 3/1", u_dut.cred0, bus.ovf_err);
    end
    pulse_clr();
    checks++;
    if (bus.ovf_err !== 1'b0 || bus.miss_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: ovf %b miss %b want 0/0", bus.ovf_err, bus.miss_err);
    end
    bus.err_clr = 1'b1;
    pulse_ld(2'b01);
    bus.err_clr = 1'b0;
    checks++;
    if (bus.ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins: got %b want 1", bus.ovf_err);
    end
    pulse_clr();
  endtask

  task automatic test_underrun();
    int vl, waited, len, bad;
    bus.fifo0_empty = 1'b1;
    pulse_fs(MODE_CAM0);
    wait_vsync(vl);
    capture_line(50, -1, 2'd0, waited, len);
    bus.fifo0_empty = 1'b0;
    bad = 0;
    for (int i = 0; i < 640; i++) if (pix[i] !== 16'h0) bad++;
    checks++;
    if (len != 640 || bad != 0) begin
      failures++;
      $display("FAIL urun_line: len %0d nonzero %0d want 640/0", len, bad);
    end
    checks++;
    if (bus.urun_err !== 1'b1 || bus.line_cnt !== 11'd1) begin
      failures++;
      $display("FAIL urun_flag: urun %b line_cnt %0d want 1/1", bus.urun_err, bus.line_cnt);
    end
  endtask

  task automatic test_async_reset();
    int w = 0;
    while (bus.pixel_href !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pixel_href !== 1'b0 || bus.fifo0_rd_en !== 1'b0 || w >= 100) begin
      failures++;
      $display("FAIL async_rst: href %b rd0 %b wait %0d want 0/0/<100",
               bus.pixel_href, bus.fifo0_rd_en, w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (u_dut.state_q !== StIdle || u_dut.cred0 !== 2'd0 || bus.urun_err !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_state: state %0d cred0 %0d urun %b want idle/0/0",
               u_dut.state_q, u_dut.cred0, bus.urun_err);
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.mode = 2'd0;
    bus.line_done0 = 1'b0;
    bus.line_done1 = 1'b0;
    bus.fifo0_empty = 1'b0;
    bus.fifo1_empty = 1'b0;
    bus.err_clr = 1'b0;
    test_reset();
    test_sbs();
    test_blend();
    test_timeout();
    test_fs_mid_line();
    test_vact();
    test_ovf();
    test_underrun();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_line_sched.md
Name: dual_line_sched

Overview:
- Single-clock line scheduler for the dual-OV5640 combiner path.
- Per-camera line FIFOs (already in pixel-clock domain) signal completed lines. This block decides when and in what order those FIFOs are drained.
- Emits one composite RGB565 stream with regenerated vsync/href toward the display/frame-buffer writer.
- Replaces ad-hoc href OR-ing with an explicit credit-based sequencer: side-by-side, single camera, or 50/50 blend.

Parameters:
- H_ACT, 640, active pixels per camera line
- V_ACT, 720, output lines per frame
- HBLANK, 16, idle cycles inserted after every output line
- VS_LEN, 4, output vsync pulse width in cycles
- TIMEOUT, 2048, wait cycles before a missing camera line is zero-filled
- CW, 2, line-credit counter width (saturates at 2^CW-1)

Ports:
- cmos_pclk  in  1  pixel clock, all logic rising-edge
- sys_rst_n  in  1  reset; asynchronous assert, active-low
- frame_start  in  1  one-cycle pulse, start of frame
- mode  in  2  0=side-by-side (cam1 left, cam0 right), 1=cam0 only, 2=cam1 only, 3=blend
- line_done0  in  1  pulse: one full cam0 line written to FIFO0
- line_done1  in  1  pulse: one full cam1 line written to FIFO1
- fifo0_rd_en  out  1  FIFO0 read strobe
- fifo0_q  in  16  FIFO0 data; valid 1 cycle after rd_en
- fifo0_empty  in  1  FIFO0 empty
- fifo1_rd_en  out  1  FIFO1 read strobe
- fifo1_q  in  16  FIFO1 data
- fifo1_empty  in  1  FIFO1 empty
- pixel_vsync  out  1  output vsync, active-high
- pixel_href  out  1  output line valid
- pixel_data  out  16  output RGB565
- line_cnt  out  11  lines emitted in current frame
- err_clr  in  1  clears sticky error flags
- ovf_err  out  1  sticky: credit counter saturated on increment
- miss_err  out  1  sticky: timeout zero-fill occurred
- urun_err  out  1  sticky: read issued while FIFO empty

Behaviour:
- Reset: state IDLE; credits 0; latched mode 0; all outputs 0; line_cnt 0; error flags 0.
- Credits, one counter per camera:
  - +1 on line_done, -1 when a line read from that FIFO starts.
  - Simultaneous inc and dec leaves the count unchanged.
  - Increment at max saturates and sets ovf_err.
- Required sources:
  - Mode 0 and mode 3: both cameras.
  - Mode 1: cam0 only.
  - Mode 2: cam1 only.
- IDLE: outputs 0. On frame_start: latch mode, go to VSYNC.
- VSYNC: pixel_vsync=1 for VS_LEN cycles; line_cnt<=0; then WAIT.
- WAIT:
  - All required credits >0: decrement them, go to OUT_A.
  - Exactly one of two required credits >0 for TIMEOUT consecutive cycles: go to OUT_A. Present source is read and decremented; absent source contributes 16'h0000 with no rd_en and no decrement; miss_err set.
  - Timeout counter clears on leaving WAIT.
- OUT_A, H_ACT cycles:
  - Mode 0 and mode 2 read FIFO1; mode 1 reads FIFO0; mode 3 reads both.
  - Mode 0 then goes to OUT_B; other modes go to HBLANK.
- OUT_B (mode 0 only): H_ACT cycles reading FIFO0 (credit decremented on entry), then HBLANK.
  - OUT_A to OUT_B is seamless, so href stays high for 2*H_ACT contiguous cycles.
  - If cam0 was the zero-filled source, OUT_B still runs and outputs zeros.
- Output pipeline: rd_en in cycle t gives pixel_href=1 and pixel_data in cycle t+1. href is 0 whenever data is not active.
- Blend (mode 3): per channel R=(r0+r1)>>1 (5b), G=(g0+g1)>>1 (6b), B=(b0+b1)>>1 (5b), using a 1-bit-wider intermediate with truncation.
- HBLANK: HBLANK cycles, href=0, data=0. line_cnt increments on entry. Exit: line_cnt==V_ACT goes to IDLE, else WAIT.
- Underrun: rd_en while FIFO empty outputs 16'h0000 for that pixel and sets urun_err; sequencing is unchanged.
- frame_start handling:
  - In WAIT, HBLANK, or VSYNC: immediately latch mode and go to VSYNC (VSYNC restarts).
  - In OUT_A or OUT_B: held pending and taken when the line finishes (at HBLANK entry, the state goes to VSYNC).
  - Credits are never cleared by frame_start.
- Mode changes outside frame_start are ignored.
- err_clr clears all sticky flags. A same-cycle set wins over err_clr.
- Async reset mid-line: rd_en and href drop immediately; the FIFOs are reset by the same sys_rst_n.

Decomposition:
- Package dual_cmos_pkg:
  - mode constants MODE_SBS/MODE_CAM0/MODE_CAM1/MODE_BLEND
  - state encoding IDLE/VSYNC/WAIT/OUT_A/OUT_B/HBLANK
  - RGB565 field positions (R[15:11], G[10:5], B[4:0])
- Sub-module line_credit_cnt, instantiated twice: saturating up/down counter with ovf pulse.

Test Plan:
- Mode 0, frame_start, then line_done0 and line_done1 pulses -> vsync high 4 cycles; href high 1280 contiguous cycles; first 640 pixels = FIFO1 contents, next 640 = FIFO0; 16 blank cycles; line_cnt=1.
- Mode 3, FIFO0 pixel 16'hF81F and FIFO1 pixel 16'h07E0 -> output 16'h7BEF; href width 640.
- Mode 0, only line_done1 pulsed -> after 2048 WAIT cycles: 640 FIFO1 pixels, then 640 zeros; miss_err=1; credit0 remains 0.
- Five line_done0 pulses with no reads (CW=2) -> credit0=3; ovf_err=1; err_clr pulse clears it.
- frame_start mid-OUT_A in mode 1 -> the line completes all 640 pixels, then vsync; new mode latched; line_cnt restarts at 0.
- V_ACT=4 override, 4 lines emitted -> state IDLE; extra line_done pulses only raise credits; no href until the next frame_start.
